// File: rtl/vend_fsm_multi_if.sv
// Handshake/bus bundle for the multi-product vending controller.
// The controller uses the slave view; whoever drives coins, selections
// and hopper acks uses the master view.
interface vend_fsm_multi_if #(
    parameter int CREDIT_W = 8,
    parameter int N_PROD   = 4
);
    localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    logic [1:0]          coin_code;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_id;
    logic                cancel;
    logic                refill;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                vend_valid;
    logic [ID_W-1:0]     vend_id;
    logic                deny;
    logic                change_req;
    logic [N_PROD-1:0]   sold_out;
    logic                busy;

    modport slave (
        input  coin_code, sel_valid, sel_id, cancel, refill, change_ack,
        output credit, coin_reject, vend_valid, vend_id, deny, change_req,
               sold_out, busy
    );

    modport master (
        output coin_code, sel_valid, sel_id, cancel, refill, change_ack,
        input  credit, coin_reject, vend_valid, vend_id, deny, change_req,
               sold_out, busy
    );
endinterface

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller: coin credit accumulation, per-product
// price/stock checks, one-cycle vend, and unit-by-unit change return
// through a req/ack hopper. All outputs come straight from flops.
module vend_fsm_multi #(
    parameter int CREDIT_W = 8,
    parameter int N_PROD   = 4,
    // product i lives at bits [i*CREDIT_W +: CREDIT_W]: 0=75, 1=50, 2=35, 3=25
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd25, 8'd35, 8'd50, 8'd75},
    // coin code c (1..3) lives at bits [(c-1)*CREDIT_W +: CREDIT_W]: 25, 10, 5
    parameter logic [3*CREDIT_W-1:0] COIN_VALS = {8'd5, 8'd10, 8'd25},
    parameter int MAX_CREDIT  = 200,
    parameter int CHANGE_UNIT = 5,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 3
) (
    input  logic          clk,
    input  logic          rst,
    vend_fsm_multi_if.slave bus
);
    localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t                           state_q, state_d;
    logic [CREDIT_W-1:0]              credit_q, credit_d;
    logic [N_PROD-1:0][STOCK_W-1:0]   stock_q, stock_d;
    logic [ID_W-1:0]                  sel_q, sel_d;
    logic [ID_W-1:0]                  vend_id_q, vend_id_d;
    logic                             coin_reject_q, coin_reject_d;
    logic                             vend_valid_q, vend_valid_d;
    logic                             deny_q, deny_d;
    logic                             change_req_q, change_req_d;
    logic                             busy_q, busy_d;

    logic [CREDIT_W-1:0]              coin_val;
    logic [CREDIT_W:0]                coin_sum;
    logic                             coin_fits;
    logic                             coin_in;
    logic                             sel_hit;
    logic [CREDIT_W-1:0]              sel_price;
    logic [STOCK_W-1:0]               sel_stock;
    logic                             sel_ok;
    logic [CREDIT_W-1:0]              vend_price;
    logic [CREDIT_W-1:0]              credit_left;
    logic [CREDIT_W-1:0]              credit_unit_dec;

    // Table lookups: coin value, requested product's price/stock, and the
    // latched product's price. Out-of-range ids simply never hit.
    always_comb begin
        coin_val   = '0;
        sel_hit    = 1'b0;
        sel_price  = '0;
        sel_stock  = '0;
        vend_price = '0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.coin_code == 2'(c))
                coin_val = COIN_VALS[(c-1)*CREDIT_W +: CREDIT_W];
        end
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.sel_id == ID_W'(i)) begin
                sel_hit   = 1'b1;
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock_q[i];
            end
            if (sel_q == ID_W'(i))
                vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    // One extra bit on the sum so an overflowing coin is caught, not wrapped.
    assign coin_in         = (bus.coin_code != 2'd0);
    assign coin_sum        = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits       = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign sel_ok          = sel_hit && (sel_stock != '0) && (credit_q >= sel_price);
    assign credit_left     = credit_q - vend_price;
    assign credit_unit_dec = credit_q - CREDIT_W'(CHANGE_UNIT);

    // Next-state and next-output logic; cancel > sel_valid > coin in IDLE/COLLECT.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        sel_d         = sel_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        vend_valid_d  = 1'b0;
        deny_d        = 1'b0;
        change_req_d  = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel) begin
                    coin_reject_d = coin_in;
                    if (state_q == COLLECT) begin
                        state_d      = CHANGE;
                        change_req_d = 1'b1;
                    end
                end else if (bus.sel_valid) begin
                    coin_reject_d = coin_in;
                    if (state_q == COLLECT && sel_ok) begin
                        sel_d   = bus.sel_id;
                        state_d = VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_in) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if (state_q == IDLE && bus.refill) begin
                    for (int i = 0; i < N_PROD; i++)
                        stock_d[i] = STOCK_W'(STOCK_INIT);
                end
            end
            VEND: begin
                vend_valid_d  = 1'b1;
                vend_id_d     = sel_q;
                coin_reject_d = coin_in;
                deny_d        = bus.sel_valid;
                credit_d      = credit_left;
                for (int i = 0; i < N_PROD; i++) begin
                    if (sel_q == ID_W'(i))
                        stock_d[i] = stock_q[i] - STOCK_W'(1);
                end
                if (credit_left != '0) begin
                    state_d      = CHANGE;
                    change_req_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_in;
                deny_d        = bus.sel_valid;
                change_req_d  = 1'b1;
                if (bus.change_ack) begin
                    credit_d = credit_unit_dec;
                    if (credit_unit_dec == '0) begin
                        state_d      = IDLE;
                        change_req_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    // State and registered outputs; reset discards any pending change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            for (int i = 0; i < N_PROD; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            sel_q         <= '0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            vend_valid_q  <= 1'b0;
            deny_q        <= 1'b0;
            change_req_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            stock_q       <= stock_d;
            sel_q         <= sel_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            vend_valid_q  <= vend_valid_d;
            deny_q        <= deny_d;
            change_req_q  <= change_req_d;
            busy_q        <= busy_d;
        end
    end

    // Sold-out flags decode directly from the stock flops.
    for (genvar g = 0; g < N_PROD; g++) begin : g_sold
        assign bus.sold_out[g] = (stock_q[g] == '0);
    end

    assign bus.credit      = credit_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.vend_valid  = vend_valid_q;
    assign bus.vend_id     = vend_id_q;
    assign bus.deny        = deny_q;
    assign bus.change_req  = change_req_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vend_fsm_multi.sv
// Directed bench for vend_fsm_multi: stimulus tasks queue the expected
// pulse events (vend/deny/reject with credit), a negedge monitor pops and
// compares them; level outputs are checked inline after each step.
module tb_vend_fsm_multi;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic       vv;
        logic [1:0] vid;
        logic       dn;
        logic       rj;
        logic [7:0] cr;
    } ev_t;

    ev_t exp_q[$];

    vend_fsm_multi_if #(.CREDIT_W(8), .N_PROD(4)) bus ();

    vend_fsm_multi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic vv, input logic [1:0] vid, input logic dn,
                        input logic rj, input logic [7:0] cr);
        ev_t e;
        e.vv = vv; e.vid = vid; e.dn = dn; e.rj = rj; e.cr = cr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Coin insert; a rejected coin queues a reject event.
    task automatic coin(input logic [1:0] code, input logic rej, input logic [7:0] exp_cr);
        bus.coin_code = code;
        if (rej) push(1'b0, 2'd0, 1'b0, 1'b1, exp_cr);
        tick();
        bus.coin_code = 2'd0;
        chk("coin_credit", bus.credit, exp_cr);
    endtask

    // Accepted selection: VEND one cycle later, then vend pulse with new credit.
    task automatic buy(input logic [1:0] id, input logic [7:0] exp_cr, input logic exp_creq);
        bus.sel_valid = 1'b1;
        bus.sel_id    = id;
        push(1'b1, id, 1'b0, 1'b0, exp_cr);
        tick();
        bus.sel_valid = 1'b0;
        chk("vend_busy", bus.busy, 1);
        chk("vend_not_early", bus.vend_valid, 0);
        tick();
        chk("vend_credit", bus.credit, exp_cr);
        chk("vend_change_req", bus.change_req, exp_creq);
    endtask

    task automatic refuse(input logic [1:0] id, input logic [7:0] exp_cr);
        bus.sel_valid = 1'b1;
        bus.sel_id    = id;
        push(1'b0, 2'd0, 1'b1, 1'b0, exp_cr);
        tick();
        bus.sel_valid = 1'b0;
        chk("deny_credit", bus.credit, exp_cr);
    endtask

    // n back-to-back acks from credit start; ends in IDLE when it reaches 0.
    task automatic acks(input int n, input int start);
        bus.change_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("ack_credit", bus.credit, start - 5 * (i + 1));
        end
        bus.change_ack = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (bus.vend_valid || bus.deny || bus.coin_reject)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {bus.vend_valid, bus.deny, bus.coin_reject}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("ev_vend_valid", bus.vend_valid, e.vv);
                    chk("ev_deny", bus.deny, e.dn);
                    chk("ev_coin_reject", bus.coin_reject, e.rj);
                    chk("ev_credit", bus.credit, e.cr);
                    if (e.vv) chk("ev_vend_id", bus.vend_id, e.vid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.coin_code  = 2'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 2'd0;
        bus.cancel     = 1'b0;
        bus.refill     = 1'b0;
        bus.change_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_credit", bus.credit, 0);
        chk("rst_change_req", bus.change_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sold_out", bus.sold_out, 0);
        chk("rst_vend_id", bus.vend_id, 0);

        // exact-price purchase, no change
        coin(2'd1, 1'b0, 8'd25);
        coin(2'd1, 1'b0, 8'd50);
        coin(2'd1, 1'b0, 8'd75);
        buy(2'd0, 8'd0, 1'b0);
        tick();
        chk("exact_busy", bus.busy, 0);
        chk("exact_sold_out", bus.sold_out, 0);

        // purchase with 15 change returned over 3 back-to-back acks
        coin(2'd1, 1'b0, 8'd25);
        coin(2'd1, 1'b0, 8'd50);
        buy(2'd2, 8'd15, 1'b1);
        chk("change_busy", bus.busy, 1);
        acks(3, 15);
        chk("change_done_req", bus.change_req, 0);
        chk("change_done_busy", bus.busy, 0);

        // MAX_CREDIT boundary
        for (int i = 0; i < 7; i++) coin(2'd1, 1'b0, 8'(25 * (i + 1)));
        coin(2'd2, 1'b0, 8'd185);
        coin(2'd3, 1'b0, 8'd190);
        coin(2'd1, 1'b1, 8'd190);
        coin(2'd2, 1'b0, 8'd200);
        coin(2'd3, 1'b1, 8'd200);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_change_req", bus.change_req, 1);
        coin(2'd3, 1'b1, 8'd200);          // coin during CHANGE is refused
        acks(40, 200);
        chk("max_done_req", bus.change_req, 0);

        // deny paths, sell out product 3, refill
        refuse(2'd1, 8'd0);                 // select in IDLE
        coin(2'd1, 1'b0, 8'd25);
        refuse(2'd1, 8'd25);                // price 50 > credit 25
        buy(2'd3, 8'd0, 1'b0);
        coin(2'd1, 1'b0, 8'd25);
        buy(2'd3, 8'd0, 1'b0);
        coin(2'd1, 1'b0, 8'd25);
        buy(2'd3, 8'd0, 1'b0);
        tick();
        chk("sold_out_3", bus.sold_out, 4'b1000);
        coin(2'd1, 1'b0, 8'd25);
        refuse(2'd3, 8'd25);                // sold out
        bus.refill = 1'b1;                  // not IDLE: ignored
        tick();
        bus.refill = 1'b0;
        chk("refill_ignored", bus.sold_out, 4'b1000);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        acks(5, 25);
        bus.refill = 1'b1;
        tick();
        bus.refill = 1'b0;
        chk("refill_idle", bus.sold_out, 0);

        // cancel with a coin in the same cycle
        coin(2'd1, 1'b0, 8'd25);
        coin(2'd3, 1'b0, 8'd30);
        bus.cancel    = 1'b1;
        bus.coin_code = 2'd2;
        push(1'b0, 2'd0, 1'b0, 1'b1, 8'd30);
        tick();
        bus.cancel    = 1'b0;
        bus.coin_code = 2'd0;
        chk("cc_change_req", bus.change_req, 1);
        chk("cc_credit", bus.credit, 30);
        acks(6, 30);
        chk("cc_done_req", bus.change_req, 0);

        // reset in the middle of CHANGE
        coin(2'd1, 1'b0, 8'd25);
        coin(2'd2, 1'b0, 8'd35);
        coin(2'd3, 1'b0, 8'd40);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        acks(2, 40);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_credit", bus.credit, 0);
        chk("mid_rst_change_req", bus.change_req, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sold_out", bus.sold_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        coin(2'd3, 1'b0, 8'd5);
        chk("post_rst_busy", bus.busy, 0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        acks(1, 5);
        chk("post_rst_req", bus.change_req, 0);

        tick();
        chk("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
